ibex_fp_regfile_sb: RTL and testbench
=====================================

// Module: ibex_fp_regfile_sb
// PURPOSE
//   Parametrised FP register file with an integrated busy scoreboard, sitting between the FPU
//   decode/issue stage and ibex_FPU writeback. Multi-ported reads, optional same-cycle write-through,
//   N write ports (single-cycle and multi-cycle FPU results), rd reservation at issue for RAW/WAW
//   hazard detection on long ops (FPU_DIV, FPU_SQRT).
// PARAMETERS
//   NUM_REGS      32  number of FP registers (power of 2, >=2); AW = $clog2(NUM_REGS) (localparam)
//   DATA_WIDTH    32  register width in bits (32 = single precision)
//   NUM_RD_PORTS  3   read ports (rs1/rs2/rs3 for fused ops)
//   NUM_WR_PORTS  2   write ports; higher index = higher priority
//   BYPASS        1   1: same-cycle write data forwarded to reads; 0: reads see stored value only
// PORTS
//   clk_i          in   1                    clock, all state updates on rising edge
//   rst_i          in   1                    asynchronous reset, active-high
//   raddr_i        in   NUM_RD_PORTS*AW      read addresses, port p at [p*AW +: AW]
//   rdata_o        out  NUM_RD_PORTS*DATA_WIDTH  read data, combinational
//   rbusy_o        out  NUM_RD_PORTS         read source pending (RAW hazard), combinational
//   we_i           in   NUM_WR_PORTS         write enable per port
//   waddr_i        in   NUM_WR_PORTS*AW      write addresses
//   wdata_i        in   NUM_WR_PORTS*DATA_WIDTH  write data
//   rsv_valid_i    in   1                    issue request reserving a destination
//   rsv_addr_i     in   AW                   destination being reserved
//   rsv_ready_o    out  1                    reservation accepted this cycle (valid&ready = handshake)
//   busy_o         out  NUM_REGS             scoreboard vector, registered
//   wr_conflict_o  out  1                    registered 1-cycle pulse: >=2 write ports hit same addr
// BEHAVIOUR
//   Reset (async assert, sync-safe release): all registers = 0, busy_o = 0, wr_conflict_o = 0.
//   No hardwired-zero register; f0 is writable.
//   Write: on posedge, for each addr, the highest-index port with we_i=1 to it writes; lower ports
//     to the same addr are dropped. Writes to addr >= NUM_REGS ignored. Write latency 1 cycle.
//   wr_conflict_o <= 1 in the cycle after any two enabled ports share waddr; else 0.
//   Read: rdata_o = reg[raddr]; if BYPASS=1 and a write to raddr is enabled this cycle, rdata_o =
//     winning wdata. raddr >= NUM_REGS -> rdata_o = 0, rbusy_o = 0.
//   rbusy_o[p] = busy[raddr_p] & ~(BYPASS & write to raddr_p this cycle).
//   Scoreboard per register, 2 states: FREE(0) / PENDING(1).
//     FREE->PENDING: rsv_valid_i & rsv_ready_o & rsv_addr_i==r.
//     PENDING->FREE: any enabled write to r, unless reserved again the same cycle.
//     Same-cycle write + reserve to same r: reservation wins (ends PENDING); data is still written.
//     Write to a FREE register (single-cycle op, no reservation): data written, busy stays 0.
//   rsv_ready_o = (rsv_addr_i < NUM_REGS) & (~busy[rsv_addr_i] | write to rsv_addr_i this cycle).
//     Combinational, independent of rsv_valid_i. Stalls WAW on an outstanding long op.
//   Reset mid-operation: all reservations and data lost, busy_o = 0 immediately (async).
//   No combinational path from rsv_valid_i to any output.
// TESTING
//   1. Write f1=0x4023d70a (port0) and f2=0x41200000 (port1), read f1/f2 next cycle ->
//      rdata = 0x4023d70a / 0x41200000, rbusy = 0.
//   2. BYPASS=1: write f3=0x4148f5c3 while raddr0=3 -> rdata0=0x4148f5c3 in the same cycle;
//      BYPASS=0 -> old value 0.
//   3. Reserve f7 (valid&ready), next cycle raddr1=7 -> rbusy1=1 and a second reserve to f7 ->
//      rsv_ready_o=0; write f7 via port1 -> busy_o[7]=0 next cycle.
//   4. Both ports write f5 (0x11111111 / 0x22222222) -> f5=0x22222222, wr_conflict_o=1 for exactly
//      one cycle.
//   5. f7 busy, same cycle write f7 and reserve f7 -> rsv_ready_o=1, data updated, busy_o[7] stays 1.
//   6. Assert rst_i asynchronously between edges while busy_o=0x80 -> busy_o=0 and all rdata=0
//      before the next edge.

Source files
------------

// File: rtl/ibex_fp_regfile_sb.sv
// ibex_fp_regfile_sb: FP register file with prioritised write ports, optional bypass and busy scoreboard
module ibex_fp_regfile_sb #(
  parameter int NUM_REGS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RD_PORTS = 3,
  parameter int NUM_WR_PORTS = 2,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_RD_PORTS*AW-1:0]         raddr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RD_PORTS-1:0]            rbusy_o,
  input  logic [NUM_WR_PORTS-1:0]            we_i,
  input  logic [NUM_WR_PORTS*AW-1:0]         waddr_i,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic                               rsv_valid_i,
  input  logic [AW-1:0]                      rsv_addr_i,
  output logic                               rsv_ready_o,
  output logic [NUM_REGS-1:0]                busy_o,
  output logic                               wr_conflict_o
);
  localparam bit BP = BYPASS != 0;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_data [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit, busy_q, busy_d;
  logic wr_conflict_q, wr_conflict_d;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Ascending port scan: a later (higher-index) port overwrites the winner for its address.
  always_comb begin
    wr_hit = '0;
    wr_conflict_d = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) wr_data[r] = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (we_i[p] && in_range(waddr_i[p*AW +: AW])) begin
        wr_hit[waddr_i[p*AW +: AW]] = 1'b1;
        wr_data[waddr_i[p*AW +: AW]] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int q = 0; q < p; q++)
        if (we_i[p] && we_i[q] && waddr_i[p*AW +: AW] == waddr_i[q*AW +: AW]) wr_conflict_d = 1'b1;
    end
  end

  assign rsv_ready_o = in_range(rsv_addr_i) && (!busy_q[rsv_addr_i] || wr_hit[rsv_addr_i]);

  // A new reservation takes precedence over the completing write to the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = wr_hit[r] ? wr_data[r] : regs_q[r];
    busy_d = busy_q & ~wr_hit;
    if (rsv_valid_i && rsv_ready_o) busy_d[rsv_addr_i] = 1'b1;
  end

  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd
    logic [AW-1:0] a;
    logic byp;
    assign a = raddr_i[g*AW +: AW];
    assign byp = BP && wr_hit[a];
    assign rdata_o[g*DATA_WIDTH +: DATA_WIDTH] = !in_range(a) ? '0 : byp ? wr_data[a] : regs_q[a];
    assign rbusy_o[g] = in_range(a) && busy_q[a] && !byp;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign busy_o = busy_q;
  assign wr_conflict_o = wr_conflict_q;
endmodule

// File: tb/tb_ibex_fp_regfile_sb.sv
// tb_ibex_fp_regfile_sb: directed and random checks of bypass and non-bypass instances against an array model
module tb_ibex_fp_regfile_sb;
  localparam int NR = 32, AW = 5, DW = 32, NRP = 3, NWP = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NRP*AW-1:0] raddr;
  logic [NRP*DW-1:0] rdata1, rdata0;
  logic [NRP-1:0] rbusy1, rbusy0;
  logic [NWP-1:0] we;
  logic [NWP*AW-1:0] waddr;
  logic [NWP*DW-1:0] wdata;
  logic rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic rdy1, rdy0, conf1, conf0;
  logic [NR-1:0] busy1, busy0;
  int errors = 0, checks = 0;
  logic [DW-1:0] mem [NR];
  logic [NR-1:0] mbusy;
  logic mconf;

  ibex_fp_regfile_sb #(.BYPASS(1)) dut1 (.clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata1),
    .rbusy_o(rbusy1), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(rdy1), .busy_o(busy1), .wr_conflict_o(conf1));
  ibex_fp_regfile_sb #(.BYPASS(0)) dut0 (.clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata0),
    .rbusy_o(rbusy0), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .rsv_ready_o(rdy0), .busy_o(busy0), .wr_conflict_o(conf0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic [AW-1:0] a);
    logic h = 1'b0;
    for (int p = 0; p < NWP; p++) if (we[p] && waddr[p*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] wval(input logic [AW-1:0] a);
    logic [DW-1:0] v = '0;
    for (int p = 0; p < NWP; p++) if (we[p] && waddr[p*AW +: AW] == a) v = wdata[p*DW +: DW];
    return v;
  endfunction

  function automatic logic exp_rdy();
    return !mbusy[rsv_addr] || hit(rsv_addr);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mem[r] = '0;
    mbusy = '0;
    mconf = 1'b0;
  endtask

  task automatic idle();
    we = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic set_w(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_r(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic check_comb();
    for (int p = 0; p < NRP; p++) begin
      logic [AW-1:0] a = raddr[p*AW +: AW];
      chk($sformatf("rdata_byp%0d", p), rdata1[p*DW +: DW], hit(a) ? wval(a) : mem[a]);
      chk($sformatf("rdata_nobyp%0d", p), rdata0[p*DW +: DW], mem[a]);
      chk($sformatf("rbusy_byp%0d", p), rbusy1[p], mbusy[a] && !hit(a));
      chk($sformatf("rbusy_nobyp%0d", p), rbusy0[p], mbusy[a]);
    end
    chk("rsv_ready", {rdy1, rdy0}, {2{exp_rdy()}});
  endtask

  task automatic tick();
    logic [DW-1:0] nmem [NR];
    logic [NR-1:0] nbusy;
    logic nconf = 1'b0;
    for (int r = 0; r < NR; r++) begin
      nmem[r] = hit(AW'(r)) ? wval(AW'(r)) : mem[r];
      nbusy[r] = (mbusy[r] && !hit(AW'(r))) || (rsv_valid && exp_rdy() && rsv_addr == AW'(r));
    end
    for (int i = 0; i < NWP; i++)
      for (int j = i + 1; j < NWP; j++)
        if (we[i] && we[j] && waddr[i*AW +: AW] == waddr[j*AW +: AW]) nconf = 1'b1;
    @(posedge clk);
    #1;
    mem = nmem;
    mbusy = nbusy;
    mconf = nconf;
    chk("busy_o", {busy1, busy0}, {2{mbusy}});
    chk("wr_conflict", {conf1, conf0}, {2{mconf}});
  endtask

  initial begin
    idle();
    raddr = '0;
    waddr = '0;
    wdata = '0;
    rsv_addr = '0;
    model_reset();
    #12;
    chk("reset_busy", busy1, '0);
    chk("reset_conf", conf1, 1'b0);
    chk("reset_rdata", rdata1, '0);
    @(negedge clk);
    rst = 1'b0;
    set_w(0, 1, 32'h4023d70a);
    set_w(1, 2, 32'h41200000);
    #1 check_comb();
    tick();
    idle();
    set_r(0, 1);
    set_r(1, 2);
    #1 check_comb();
    chk("t1_f1", rdata1[31:0], 32'h4023d70a);
    chk("t1_f2", rdata1[63:32], 32'h41200000);
    chk("t1_rbusy", rbusy1[1:0], 2'b00);
    set_w(0, 3, 32'h4148f5c3);
    set_r(0, 3);
    #1 check_comb();
    chk("t2_bypass", rdata1[31:0], 32'h4148f5c3);
    chk("t2_nobypass", rdata0[31:0], 32'h0);
    tick();
    idle();
    rsv_valid = 1'b1;
    rsv_addr = 7;
    #1 check_comb();
    chk("t3_rdy_first", rdy1, 1'b1);
    tick();
    chk("t3_busy7", busy1[7], 1'b1);
    set_r(1, 7);
    #1 check_comb();
    chk("t3_rbusy1", rbusy1[1], 1'b1);
    chk("t3_rdy_second", rdy1, 1'b0);
    tick();
    idle();
    set_w(1, 7, 32'hdeadbeef);
    #1 check_comb();
    tick();
    chk("t3_busy7_clear", busy1[7], 1'b0);
    idle();
    set_w(0, 5, 32'h11111111);
    set_w(1, 5, 32'h22222222);
    #1 check_comb();
    tick();
    chk("t4_conf_hi", conf1, 1'b1);
    idle();
    set_r(2, 5);
    #1 check_comb();
    chk("t4_f5", rdata1[95:64], 32'h22222222);
    tick();
    chk("t4_conf_lo", conf1, 1'b0);
    rsv_valid = 1'b1;
    rsv_addr = 7;
    #1 check_comb();
    tick();
    set_w(0, 7, 32'h3f800000);
    #1 check_comb();
    chk("t5_rdy", rdy1, 1'b1);
    tick();
    chk("t5_busy7", busy1[7], 1'b1);
    idle();
    set_r(0, 7);
    #1 check_comb();
    chk("t5_data", rdata1[31:0], 32'h3f800000);
    chk("t6_pre_busy", busy1, 32'h80);
    set_r(1, 2);
    set_r(2, 5);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", {busy1, busy0}, '0);
    chk("t6_rdata", {rdata1, rdata0}, '0);
    chk("t6_conf", conf1, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (400) begin
      we = NWP'($urandom);
      for (int p = 0; p < NWP; p++) begin
        waddr[p*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wdata[p*DW +: DW] = $urandom;
      end
      for (int p = 0; p < NRP; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
      rsv_valid = $urandom_range(0, 1) == 1;
      rsv_addr = AW'($urandom_range(0, 7));
      #1 check_comb();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
